beep_melody_ctrl: RTL and testbench

// Sequencer for the buzzer PWM datapath. Steps through a fixed note table, loading

---
 rtl/beep_pkg.sv | 36 +++
 rtl/beep_note_rom.sv | 40 ++++
 rtl/beep_melody_ctrl.sv | 161 ++++++++++++++++
 tb/tb_beep_melody_ctrl.sv | 226 ++++++++++++++++++++++
 4 files changed

// File: rtl/beep_pkg.sv
// Shared types and pitch constants for the buzzer melody sequencer.
// The periods are in 50 MHz clock cycles.
package beep_pkg;

    localparam int ROM_PERIOD_W = 20;
    localparam int ROM_DUR_W    = 10;

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        PLAY,
        GAP,
        DONE
    } state_t;

    typedef struct packed {
        logic [ROM_PERIOD_W-1:0] period;
        logic [ROM_DUR_W-1:0]    dur_ms;
    } note_t;

    // Each period is 50e6 / f_note, where f_note is the equal-tempered pitch.
    localparam logic [ROM_PERIOD_W-1:0] NOTE_C4   = 20'd191113;
    localparam logic [ROM_PERIOD_W-1:0] NOTE_D4   = 20'd170262;
    localparam logic [ROM_PERIOD_W-1:0] NOTE_E4   = 20'd151686;
    localparam logic [ROM_PERIOD_W-1:0] NOTE_F4   = 20'd143173;
    localparam logic [ROM_PERIOD_W-1:0] NOTE_G4   = 20'd127553;
    localparam logic [ROM_PERIOD_W-1:0] NOTE_A4   = 20'd113636;
    localparam logic [ROM_PERIOD_W-1:0] NOTE_B4   = 20'd101239;
    localparam logic [ROM_PERIOD_W-1:0] NOTE_C5   = 20'd95556;
    localparam logic [ROM_PERIOD_W-1:0] NOTE_REST = '0;

    localparam logic [ROM_DUR_W-1:0] BEAT_MS = 10'd250;

    localparam note_t REST_1MS = '{period: NOTE_REST, dur_ms: 10'd1};

endpackage

// File: rtl/beep_note_rom.sv
// Combinational note table: address -> {period, duration}.
// An address past the end of the selected table plays a 1 ms rest.
module beep_note_rom
    import beep_pkg::*;
#(
    parameter int TABLE_SEL = 0
) (
    input  logic [7:0] addr,
    output note_t      note
);

    always_comb begin
        // NOTE: default first, so every path assigns note and no latch is inferred.
        note = REST_1MS;
        if (TABLE_SEL == 0) begin
            // C major scale. The top note is held for two beats.
            case (addr)
                8'd0:    note = '{period: NOTE_C4, dur_ms: BEAT_MS};
                8'd1:    note = '{period: NOTE_D4, dur_ms: BEAT_MS};
                8'd2:    note = '{period: NOTE_E4, dur_ms: BEAT_MS};
                8'd3:    note = '{period: NOTE_F4, dur_ms: BEAT_MS};
                8'd4:    note = '{period: NOTE_G4, dur_ms: BEAT_MS};
                8'd5:    note = '{period: NOTE_A4, dur_ms: BEAT_MS};
                8'd6:    note = '{period: NOTE_B4, dur_ms: BEAT_MS};
                8'd7:    note = '{period: NOTE_C5, dur_ms: 10'd500};
                default: note = REST_1MS;
            endcase
        end else begin
            // Short table for fast clocks: two tones, a rest, then a zero-length entry.
            case (addr)
                8'd0:    note = '{period: 20'd100,   dur_ms: 10'd2};
                8'd1:    note = '{period: 20'd200,   dur_ms: 10'd3};
                8'd2:    note = '{period: NOTE_REST, dur_ms: 10'd1};
                8'd3:    note = '{period: 20'd60,    dur_ms: 10'd0};
                default: note = REST_1MS;
            endcase
        end
    end

endmodule

// File: rtl/beep_melody_ctrl.sv
// Melody sequencer: walks the note table and loads period/duty into the PWM generator.
// Each note is held for its duration and is followed by a silent gap.
module beep_melody_ctrl
    import beep_pkg::*;
#(
    parameter int CLK_FREQ   = 50_000_000,
    parameter int NOTE_NUM   = 8,
    parameter int PERIOD_W   = 20,
    parameter int DUR_W      = 10,
    parameter int GAP_MS     = 20,
    parameter int DUTY_SHIFT = 1,
    parameter int TABLE_SEL  = 0
) (
    input  logic                sys_clk,
    input  logic                sys_rst,
    input  logic                start,
    input  logic                stop,
    input  logic                loop_en,
    output logic                busy,
    output logic                done,
    output logic [7:0]          note_idx,
    output logic                cfg_load,
    output logic                pwm_en,
    output logic [PERIOD_W-1:0] pwm_period,
    output logic [PERIOD_W-1:0] pwm_duty
);

    localparam int TICK  = CLK_FREQ / 1000;
    localparam int PRE_W = (TICK > 1) ? $clog2(TICK) : 1;
    localparam int GAP_W = (GAP_MS > 0) ? $clog2(GAP_MS + 1) : 1;
    localparam int MS_W  = (DUR_W > GAP_W) ? DUR_W : GAP_W;

    localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(TICK - 1);
    localparam logic [MS_W-1:0]  GAP_LAST = MS_W'((GAP_MS > 0) ? GAP_MS - 1 : 0);
    localparam logic [7:0]       IDX_LAST = 8'(NOTE_NUM - 1);

    state_t              state;
    state_t              seq_state;
    logic [7:0]          seq_idx;
    logic                start_q;
    logic [PRE_W-1:0]    pre_cnt;
    logic [MS_W-1:0]     ms_cnt;
    note_t               rom_note;
    logic [PERIOD_W-1:0] rom_period;
    logic [MS_W-1:0]     play_last;
    logic                ms_tick;

    beep_note_rom #(
        .TABLE_SEL (TABLE_SEL)
    ) u_note_rom (
        .addr (note_idx),
        .note (rom_note)
    );

    always_comb begin
        rom_period = PERIOD_W'(rom_note.period);
        play_last  = (rom_note.dur_ms == '0) ? '0 : MS_W'(rom_note.dur_ms - 1'b1);
        ms_tick    = (pre_cnt == PRE_LAST);
        // What follows the current note: the next entry, a wrap to entry 0, or the end of the pass.
        if (note_idx != IDX_LAST) begin
            seq_state = LOAD;
            seq_idx   = note_idx + 8'd1;
        end else if (loop_en) begin
            seq_state = LOAD;
            seq_idx   = '0;
        end else begin
            seq_state = DONE;
            seq_idx   = note_idx;
        end
    end

    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            state      <= IDLE;
            start_q    <= 1'b0;
            pre_cnt    <= '0;
            ms_cnt     <= '0;
            busy       <= 1'b0;
            done       <= 1'b0;
            note_idx   <= '0;
            cfg_load   <= 1'b0;
            pwm_en     <= 1'b0;
            pwm_period <= '0;
            pwm_duty   <= '0;
        end else begin
            // NOTE: non-blocking only; a later assignment in this block overrides these strobe defaults.
            cfg_load <= 1'b0;
            done     <= 1'b0;
            // Start is captured one cycle ahead of the IDLE decision. A start that arrives
            // together with stop, or outside IDLE, is never captured.
            start_q  <= start && !stop && (state == IDLE);

            if (state != IDLE && (stop || state == DONE)) begin
                state      <= IDLE;
                busy       <= 1'b0;
                pwm_en     <= 1'b0;
                note_idx   <= '0;
                pwm_period <= '0;
                pwm_duty   <= '0;
                pre_cnt    <= '0;
                ms_cnt     <= '0;
            end else begin
                case (state)
                    IDLE: begin
                        if (start_q && !stop) begin
                            state    <= LOAD;
                            busy     <= 1'b1;
                            note_idx <= '0;
                        end
                    end
                    LOAD: begin
                        state      <= PLAY;
                        pwm_period <= rom_period;
                        pwm_duty   <= rom_period >> DUTY_SHIFT;
                        cfg_load   <= 1'b1;
                        pwm_en     <= |rom_period;
                        pre_cnt    <= '0;
                        ms_cnt     <= '0;
                    end
                    PLAY: begin
                        if (!ms_tick) begin
                            pre_cnt <= pre_cnt + 1'b1;
                        end else begin
                            pre_cnt <= '0;
                            if (ms_cnt != play_last) begin
                                ms_cnt <= ms_cnt + 1'b1;
                            end else begin
                                ms_cnt <= '0;
                                pwm_en <= 1'b0;
                                if (GAP_MS > 0) begin
                                    state <= GAP;
                                end else begin
                                    state    <= seq_state;
                                    note_idx <= seq_idx;
                                    done     <= (seq_state == DONE);
                                end
                            end
                        end
                    end
                    GAP: begin
                        if (!ms_tick) begin
                            pre_cnt <= pre_cnt + 1'b1;
                        end else begin
                            pre_cnt <= '0;
                            if (ms_cnt != GAP_LAST) begin
                                ms_cnt <= ms_cnt + 1'b1;
                            end else begin
                                ms_cnt   <= '0;
                                state    <= seq_state;
                                note_idx <= seq_idx;
                                done     <= (seq_state == DONE);
                            end
                        end
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_beep_melody_ctrl.sv
// Randomized bench for beep_melody_ctrl. A trace model produces the expected outputs for
// each cycle, working from the note table, the note durations and the gap length.
module tb_beep_melody_ctrl;

    localparam int TICK    = 10;
    localparam int GAP_CYC = 10;

    logic        sys_clk = 1'b0;
    logic        sys_rst = 1'b1;
    logic        a_start = 1'b0;
    logic        b_start = 1'b0;
    logic        stop    = 1'b0;
    logic        loop_en = 1'b0;

    logic        a_busy, a_done, a_cfg_load, a_pwm_en;
    logic [7:0]  a_note_idx;
    logic [19:0] a_pwm_period, a_pwm_duty;
    logic        b_busy, b_done, b_cfg_load, b_pwm_en;
    logic [7:0]  b_note_idx;
    logic [19:0] b_pwm_period, b_pwm_duty;
    logic [51:0] obs_a, obs_b;

    int checks = 0;
    int errors = 0;

    always #5 sys_clk = ~sys_clk;

    beep_melody_ctrl #(
        .CLK_FREQ(10_000), .NOTE_NUM(3), .PERIOD_W(20), .DUR_W(10),
        .GAP_MS(1), .DUTY_SHIFT(1), .TABLE_SEL(1)
    ) dut_a (
        .sys_clk(sys_clk), .sys_rst(sys_rst), .start(a_start), .stop(stop),
        .loop_en(loop_en), .busy(a_busy), .done(a_done), .note_idx(a_note_idx),
        .cfg_load(a_cfg_load), .pwm_en(a_pwm_en), .pwm_period(a_pwm_period),
        .pwm_duty(a_pwm_duty)
    );

    // Second instance plays the fourth entry, whose duration field is zero.
    beep_melody_ctrl #(
        .CLK_FREQ(10_000), .NOTE_NUM(4), .PERIOD_W(20), .DUR_W(10),
        .GAP_MS(1), .DUTY_SHIFT(1), .TABLE_SEL(1)
    ) dut_b (
        .sys_clk(sys_clk), .sys_rst(sys_rst), .start(b_start), .stop(stop),
        .loop_en(loop_en), .busy(b_busy), .done(b_done), .note_idx(b_note_idx),
        .cfg_load(b_cfg_load), .pwm_en(b_pwm_en), .pwm_period(b_pwm_period),
        .pwm_duty(b_pwm_duty)
    );

    assign obs_a = {a_busy, a_done, a_cfg_load, a_pwm_en, a_note_idx, a_pwm_period, a_pwm_duty};
    assign obs_b = {b_busy, b_done, b_cfg_load, b_pwm_en, b_note_idx, b_pwm_period, b_pwm_duty};

    typedef struct {
        bit busy;
        bit done;
        bit cfg_load;
        bit pwm_en;
        bit decide;
        int idx;
        int period;
        int duty;
    } exp_t;

    int   tbl_per[4] = '{100, 200, 0, 60};
    int   tbl_dur[4] = '{2, 3, 1, 0};
    exp_t exp_q[$];
    bit   plan[$];

    task automatic check(input string tag, input logic [51:0] got, input logic [51:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic exp_t mk(input bit busy, input bit done, input bit cfg, input bit en,
                                input bit dec, input int idx, input int p);
        exp_t r;
        r.busy     = busy;
        r.done     = done;
        r.cfg_load = cfg;
        r.pwm_en   = en;
        r.decide   = dec;
        r.idx      = idx;
        r.period   = p;
        r.duty     = p / 2;
        return r;
    endfunction

    function automatic logic [51:0] pk(input exp_t r);
        return {r.busy, r.done, r.cfg_load, r.pwm_en, 8'(r.idx), 20'(r.period), 20'(r.duty)};
    endfunction

    // Expected output for every cycle of one pass. Row 0 is the cycle right after start is
    // sampled. The plan queue gives the loop_en value at each end-of-table decision.
    function automatic void build(input int nn);
        int idx    = 0;
        int prev_p = 0;
        int p      = 0;
        int wrap   = 0;
        int n;
        bit fin    = 0;
        exp_q.delete();
        exp_q.push_back(mk(0, 0, 0, 0, 0, 0, 0));
        while (!fin) begin
            exp_q.push_back(mk(1, 0, 0, 0, 0, idx, prev_p));
            p = tbl_per[idx];
            n = ((tbl_dur[idx] == 0) ? 1 : tbl_dur[idx]) * TICK;
            for (int c = 0; c < n; c++)
                exp_q.push_back(mk(1, 0, c == 0, p != 0, 0, idx, p));
            for (int c = 0; c < GAP_CYC; c++)
                exp_q.push_back(mk(1, 0, 0, 0, (c == GAP_CYC - 1) && (idx == nn - 1), idx, p));
            prev_p = p;
            if (idx < nn - 1) begin
                idx++;
            end else if (wrap < plan.size() && plan[wrap]) begin
                wrap++;
                idx = 0;
            end else begin
                fin = 1;
            end
        end
        exp_q.push_back(mk(1, 1, 0, 0, 0, idx, p));
        exp_q.push_back(mk(0, 0, 0, 0, 0, 0, 0));
    endfunction

    // stop_at: -1 = never, -2 = at a random row, otherwise stop is raised after that row.
    task automatic run_pass(input bit use_b, input int wraps, input int stop_at,
                            input bit noisy, input string name);
        int          dec = 0;
        int          s;
        exp_t        r;
        exp_t        idle_r;
        logic [51:0] obs;
        plan.delete();
        repeat (wraps) plan.push_back(1'b1);
        plan.push_back(1'b0);
        build(use_b ? 4 : 3);
        idle_r = mk(0, 0, 0, 0, 0, 0, 0);
        if (stop_at == -2)      s = $urandom_range(1, exp_q.size() - 2);
        else if (stop_at == -1) s = exp_q.size() + 1;
        else                    s = stop_at;
        @(negedge sys_clk);
        if (use_b) b_start = 1'b1; else a_start = 1'b1;
        for (int j = 0; j < exp_q.size(); j++) begin
            @(negedge sys_clk);
            r   = (j > s) ? idle_r : exp_q[j];
            obs = use_b ? obs_b : obs_a;
            check($sformatf("%s_c%0d", name, j), obs, pk(r));
            a_start = 1'b0;
            b_start = 1'b0;
            stop    = 1'b0;
            if (j > s) break;
            if (j == s) begin
                stop = 1'b1;
            end else if (noisy && j >= 1 && j <= exp_q.size() - 2 && $urandom_range(0, 3) == 0) begin
                if (use_b) b_start = 1'b1; else a_start = 1'b1;
            end
            if (exp_q[j].decide) begin
                loop_en = plan[dec];
                dec++;
            end else begin
                loop_en = 1'($urandom_range(0, 1));
            end
        end
        a_start = 1'b0;
        b_start = 1'b0;
        stop    = 1'b0;
        check({name, "_other_idle"}, use_b ? obs_a : obs_b, 52'd0);
    endtask

    initial begin
        repeat (3) @(negedge sys_clk);
        check("rst_a", obs_a, 52'd0);
        check("rst_b", obs_b, 52'd0);
        sys_rst = 1'b0;

        run_pass(1'b0, 0, -1, 1'b0, "plain");
        run_pass(1'b0, 0, 10, 1'b0, "stop_play");
        run_pass(1'b0, 1, -1, 1'b0, "loop1");
        run_pass(1'b0, 0, -1, 1'b1, "restart_busy");
        run_pass(1'b1, 0, -1, 1'b0, "dur0");

        // Start and stop together while idle: the block stays idle.
        @(negedge sys_clk);
        a_start = 1'b1;
        stop    = 1'b1;
        @(negedge sys_clk);
        a_start = 1'b0;
        stop    = 1'b0;
        for (int k = 0; k < 4; k++) begin
            @(negedge sys_clk);
            check($sformatf("start_stop_idle%0d", k), obs_a, 52'd0);
        end

        // Reset in the middle of a note.
        @(negedge sys_clk);
        a_start = 1'b1;
        @(negedge sys_clk);
        a_start = 1'b0;
        repeat (25) @(negedge sys_clk);
        check("pre_rst_busy", {51'd0, a_busy}, 52'd1);
        sys_rst = 1'b1;
        @(negedge sys_clk);
        check("mid_rst1", obs_a, 52'd0);
        @(negedge sys_clk);
        check("mid_rst2", obs_a, 52'd0);
        sys_rst = 1'b0;

        for (int t = 0; t < 16; t++) begin
            run_pass(1'($urandom_range(0, 1)), $urandom_range(0, 2),
                     ($urandom_range(0, 1) == 1) ? -2 : -1,
                     1'($urandom_range(0, 1)), $sformatf("rnd%0d", t));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #3_000_000;
        $display("FAIL watchdog timeout checks=%0d errors=%0d", checks, errors);
        $fatal(1, "watchdog");
    end

endmodule
